// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter onto a one-command-in-flight memory port
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise req0 wins every tie.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [STRB_WIDTH-1:0] req0_wstrb,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [STRB_WIDTH-1:0] req1_wstrb,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [STRB_WIDTH-1:0] mem_write_strb,
  output logic [ADDR_WIDTH-1:0] mem_w_opt_addr,
  output logic                  mem_write_valid,
  output logic [ADDR_WIDTH-1:0] mem_r_opt_addr,
  output logic                  mem_read_req,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_read_valid
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;
  localparam int CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_write_valid;
  logic                  r_read_req;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_idle;
  logic                  w_take;
  logic                  w_grant1;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_WIDTH-1:0] w_wstrb;
  logic                  w_rsp0;
  logic                  w_rsp1;

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
`else
  assign w_grant1 = req1_valid & ~req0_valid;
`endif

  // ready is gated by rst so every output reads 0 while reset is held
  assign w_idle     = (r_state == IDLE) & ~rst;
  assign w_take     = w_idle & (req0_valid | req1_valid);
  assign req0_ready = w_take & ~w_grant1;
  assign req1_ready = w_idle & w_grant1;

  assign w_we    = w_grant1 ? req1_we    : req0_we;
  assign w_addr  = w_grant1 ? req1_addr  : req0_addr;
  assign w_wdata = w_grant1 ? req1_wdata : req0_wdata;
  assign w_wstrb = w_grant1 ? req1_wstrb : req0_wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_owner       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_write_valid <= 1'b0;
      r_read_req    <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_grant  <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_owner <= w_grant1;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
`ifdef MEM_ARB_RR_EN
            r_last_grant <= w_grant1;
`endif
            if (w_we) begin
              r_state       <= WRITE;
              r_write_valid <= 1'b1;
              r_rsp_valid   <= 1'b1;
              r_rsp_err     <= 1'b0;
              r_rsp_rdata   <= '0;
            end else begin
              r_state    <= READ_WAIT;
              r_read_req <= 1'b1;
              r_cnt      <= '0;
            end
          end
        end
        WRITE: begin
          r_write_valid <= 1'b0;
          r_rsp_valid   <= 1'b0;
          r_state       <= IDLE;
        end
        READ_WAIT: begin
          // first-cycle read_valid is a leftover of registered memory latency
          if ((r_cnt != '0) && mem_read_valid) begin
            r_rsp_rdata <= mem_read_data;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_read_req  <= 1'b0;
            r_state     <= RESP;
          end else if (r_cnt == CW'(RD_TIMEOUT - 1)) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_read_req  <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rsp0 = r_rsp_valid & ~r_owner;
  assign w_rsp1 = r_rsp_valid & r_owner;

  assign rsp0_valid = w_rsp0;
  assign rsp0_err   = w_rsp0 & r_rsp_err;
  assign rsp0_rdata = w_rsp0 ? r_rsp_rdata : '0;
  assign rsp1_valid = w_rsp1;
  assign rsp1_err   = w_rsp1 & r_rsp_err;
  assign rsp1_rdata = w_rsp1 ? r_rsp_rdata : '0;

  assign mem_write_valid = r_write_valid;
  assign mem_write_data  = r_wdata;
  assign mem_write_strb  = r_wstrb;
  assign mem_w_opt_addr  = r_addr;
  assign mem_read_req    = r_read_req;
  assign mem_r_opt_addr  = r_addr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int DW = 32, AW = 32, SW = 4, TO = 15;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          c_valid [2];
  logic          c_we    [2];
  logic [AW-1:0] c_addr  [2];
  logic [DW-1:0] c_wdata [2];
  logic [SW-1:0] c_wstrb [2];

  logic req0_ready, req1_ready;
  logic rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [DW-1:0] mem_write_data;
  logic [SW-1:0] mem_write_strb;
  logic [AW-1:0] mem_w_opt_addr, mem_r_opt_addr;
  logic mem_write_valid, mem_read_req;
  logic [DW-1:0] mem_read_data;
  logic mem_read_valid;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(c_valid[0]), .req0_ready(req0_ready), .req0_we(c_we[0]),
    .req0_addr(c_addr[0]), .req0_wdata(c_wdata[0]), .req0_wstrb(c_wstrb[0]),
    .req1_valid(c_valid[1]), .req1_ready(req1_ready), .req1_we(c_we[1]),
    .req1_addr(c_addr[1]), .req1_wdata(c_wdata[1]), .req1_wstrb(c_wstrb[1]),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_write_data(mem_write_data), .mem_write_strb(mem_write_strb),
    .mem_w_opt_addr(mem_w_opt_addr), .mem_write_valid(mem_write_valid),
    .mem_r_opt_addr(mem_r_opt_addr), .mem_read_req(mem_read_req),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid)
  );

  int n_checks = 0;
  int n_errors = 0;
  int last_win = 1;
  int gen_mode = 0;
  logic [DW-1:0] model_mem [8];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err,
                             mem_write_valid, mem_read_req}, 0);
    check_eq({tag, "_bus"}, {rsp1_rdata, rsp0_rdata, mem_write_data, mem_write_strb}, 0);
    check_eq({tag, "_addr"}, {mem_w_opt_addr, mem_r_opt_addr}, 0);
  endtask

  task automatic gen_cmd(input int n, input bit force_valid);
    c_valid[n] = force_valid || ($urandom_range(0, 3) != 0);
    c_we[n]    = 1'($urandom_range(0, 1));
    c_addr[n]  = AW'($urandom_range(0, 7));
    c_wdata[n] = $urandom;
    c_wstrb[n] = SW'($urandom_range(0, 15));
  endtask

  // memory response delay in READ_WAIT cycles; 1000 means the memory never answers
  function automatic int pick_lat();
    int p;
    p = $urandom_range(0, 9);
    if (p <= 6) return p;
    if (p == 7) return TO - 2;
    if (p == 8) return TO - 1;
    return 1000;
  endfunction

  // Entered #1 after a posedge of an IDLE cycle with at least one request valid.
  task automatic do_txn(input int lat_in);
    int w, lat, cap, k;
    logic we, err;
    logic [1:0] wmask, emask;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_d;
    logic [SW-1:0] s;
    @(negedge clk);
    check_eq("idle_quiet", {mem_write_valid, mem_read_req, rsp1_valid, rsp0_valid}, 0);
    if (c_valid[0] && c_valid[1]) w = RR_EN ? 1 - last_win : 0;
    else w = c_valid[1] ? 1 : 0;
    wmask = 2'b01 << w;
    check_eq("grant", {req1_ready, req0_ready}, wmask);
    last_win = w;
    we = c_we[w]; a = c_addr[w]; d = c_wdata[w]; s = c_wstrb[w];
    lat = (lat_in >= 0) ? lat_in : pick_lat();
    @(posedge clk); #1;
    if (gen_mode == 0) c_valid[w] = 1'b0;
    else gen_cmd(w, gen_mode == 2);
    if (we) begin
      @(negedge clk);
      check_eq("wr_port", {mem_write_valid, mem_read_req, mem_w_opt_addr, mem_write_data, mem_write_strb},
               {1'b1, 1'b0, a, d, s});
      check_eq("wr_rsp", {rsp1_valid, rsp0_valid, rsp1_err, rsp0_err, rsp1_rdata, rsp0_rdata, req1_ready, req0_ready},
               {wmask, 2'b00, 64'd0, 2'b00});
      for (int b = 0; b < SW; b++)
        if (s[b]) model_mem[a[2:0]][8*b +: 8] = d[8*b +: 8];
      @(posedge clk); #1;
    end else begin
      cap = (lat < 1) ? 1 : lat;
      if (cap <= TO - 1) begin k = cap + 1; err = 1'b0; exp_d = model_mem[a[2:0]]; end
      else begin k = TO; err = 1'b1; exp_d = '0; end
      for (int i = 0; i < k; i++) begin
        mem_read_valid = (i >= lat);
        mem_read_data  = mem_read_valid ? model_mem[a[2:0]] : $urandom;
        @(negedge clk);
        check_eq("rd_wait", {mem_read_req, mem_write_valid, rsp1_valid, rsp0_valid, req1_ready, req0_ready, mem_r_opt_addr},
                 {1'b1, 1'b0, 2'b00, 2'b00, a});
        @(posedge clk); #1;
      end
      mem_read_valid = 1'b0;
      mem_read_data  = $urandom;
      emask = err ? wmask : 2'b00;
      @(negedge clk);
      check_eq("rd_rsp", {mem_read_req, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err}, {1'b0, wmask, emask});
      check_eq("rd_data", {rsp1_rdata, rsp0_rdata}, (w == 1) ? {exp_d, 32'd0} : {32'd0, exp_d});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    for (int n = 0; n < 2; n++) begin
      c_valid[n] = 1'b0; c_we[n] = 1'b0; c_addr[n] = '0; c_wdata[n] = '0; c_wstrb[n] = '0;
    end
    mem_read_valid = 1'b0;
    mem_read_data  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    c_valid[0] = 1'b1; c_valid[1] = 1'b1;
    #1;
    check_eq("reset_ready", {req1_ready, req0_ready}, 0);
    c_valid[0] = 1'b0; c_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // write 0xDEADBEEF to address 5 from requester 0
    c_valid[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 5; c_wdata[0] = 32'hDEADBEEF; c_wstrb[0] = 4'hF;
    do_txn(0);
    // requester 1 reads it back with a 2-cycle memory latency
    c_valid[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 5;
    do_txn(2);
    // stale-only read_valid, then a timeout read
    c_valid[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 5;
    do_txn(0);
    c_valid[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 3;
    do_txn(1000);

    // both requesters continuously busy
    gen_mode = 2;
    gen_cmd(0, 1'b1); gen_cmd(1, 1'b1);
    for (int t = 0; t < 6; t++) do_txn(-1);

    // reset in the third READ_WAIT cycle of a read
    gen_mode = 0;
    c_valid[1] = 1'b0;
    c_valid[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 2;
    @(negedge clk);
    check_eq("rst_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    c_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("rst_rdreq", mem_read_req, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_rsp", {rsp1_valid, rsp0_valid, mem_read_req}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_win = 1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_quiet", {rsp1_valid, rsp0_valid, mem_read_req, mem_write_valid}, 0);
      @(posedge clk); #1;
    end
    c_valid[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 6; c_wdata[0] = 32'h12345678; c_wstrb[0] = 4'h3;
    c_valid[1] = 1'b1; c_we[1] = 1'b1; c_addr[1] = 7; c_wdata[1] = 32'hA5A5A5A5; c_wstrb[1] = 4'hC;
    do_txn(0);
    c_valid[0] = 1'b0; c_valid[1] = 1'b0;

    // randomized traffic
    gen_mode = 1;
    gen_cmd(0, 1'b0); gen_cmd(1, 1'b0);
    for (int t = 0; t < 80; t++) begin
      if (!c_valid[0] && !c_valid[1]) begin
        @(negedge clk);
        check_eq("no_req_ready", {req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 0);
        @(posedge clk); #1;
        gen_cmd(0, 1'b0); gen_cmd(1, 1'b0);
      end else begin
        do_txn(-1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
